// File: rtl/onehot_bcd_entry.sv
// onehot_bcd_entry: one-hot keypad digit entry register with backspace/clear and a valid/ready commit holding register
module onehot_bcd_entry #(
  parameter int DIGITS     = 4,
  parameter bit STICKY_ERR = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         key_valid,
  input  logic [9:0]                   key_onehot,
  input  logic                         backspace,
  input  logic                         clear,
  input  logic                         enter,
  output logic [4*DIGITS-1:0]          entry_bcd,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         full,
  output logic                         key_accept,
  output logic                         err,
  output logic                         ovf,
  output logic [4*DIGITS-1:0]          value_bcd,
  output logic                         value_valid,
  input  logic                         value_ready
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(DIGITS);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    entry_q, entry_d, value_q, value_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            key_accept_q, key_accept_d, err_q, err_d, ovf_q, ovf_d;
  logic [3:0]      key_dig;
  logic            one_hot;

  assign one_hot     = $onehot(key_onehot);
  assign full        = cnt_q == MAX_CNT;
  assign entry_bcd   = entry_q;
  assign digit_count = cnt_q;
  assign key_accept  = key_accept_q;
  assign err         = err_q;
  assign ovf         = ovf_q;
  assign value_bcd   = value_q;
  assign value_valid = state_q == HOLD;

  // decode the one-hot key to its digit value
  always_comb begin
    key_dig = '0;
    for (int i = 0; i < 10; i++)
      if (key_onehot[i]) key_dig = 4'(i);
  end

  // next-state: clear > enter > backspace > key, with the commit handshake alongside
  always_comb begin
    entry_d      = entry_q;
    cnt_d        = cnt_q;
    key_accept_d = 1'b0;
    err_d        = STICKY_ERR ? err_q : 1'b0;
    ovf_d        = ovf_q;
    value_d      = value_q;
    state_d      = (state_q == HOLD && value_ready) ? IDLE : state_q;
    if (clear) begin
      entry_d = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
      ovf_d   = 1'b0;
    end else if (enter) begin
      if (state_q == IDLE) begin
        value_d = entry_q;
        state_d = HOLD;
        entry_d = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
        ovf_d   = 1'b0;
      end
    end else if (backspace) begin
      if (cnt_q != '0) begin
        entry_d = entry_q >> 4;
        cnt_d   = cnt_q - CW'(1);
        ovf_d   = 1'b0;
      end
    end else if (key_valid) begin
      if (!one_hot) err_d = 1'b1;
      else if (full) ovf_d = 1'b1;
      else begin
        entry_d      = W'({entry_q, key_dig});
        cnt_d        = cnt_q + CW'(1);
        key_accept_d = 1'b1;
      end
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      entry_q      <= '0;
      cnt_q        <= '0;
      key_accept_q <= 1'b0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      value_q      <= '0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      cnt_q        <= cnt_d;
      key_accept_q <= key_accept_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
      value_q      <= value_d;
    end
  end
endmodule

// File: tb/tb_onehot_bcd_entry.sv
// tb_onehot_bcd_entry: directed self-checking bench for onehot_bcd_entry (sticky and pulse err variants)
module tb_onehot_bcd_entry;
  logic clk = 1'b0, rst_n = 1'b0;
  logic key_valid = 1'b0, backspace = 1'b0, clear = 1'b0, enter = 1'b0, value_ready = 1'b0;
  logic [9:0] key_onehot = '0;
  logic [15:0] entry, value, entry0, value0;
  logic [2:0] cnt, cnt0;
  logic full, acc, err, ovf, vld, full0, acc0, err0, ovf0, vld0;
  int n_checks = 0, n_fail = 0;

  onehot_bcd_entry #(.DIGITS(4), .STICKY_ERR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_onehot(key_onehot),
    .backspace(backspace), .clear(clear), .enter(enter), .entry_bcd(entry),
    .digit_count(cnt), .full(full), .key_accept(acc), .err(err), .ovf(ovf),
    .value_bcd(value), .value_valid(vld), .value_ready(value_ready));

  onehot_bcd_entry #(.DIGITS(4), .STICKY_ERR(1'b0)) dut_pulse (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_onehot(key_onehot),
    .backspace(backspace), .clear(clear), .enter(enter), .entry_bcd(entry0),
    .digit_count(cnt0), .full(full0), .key_accept(acc0), .err(err0), .ovf(ovf0),
    .value_bcd(value0), .value_valid(vld0), .value_ready(value_ready));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [9:0] k);
    key_valid = 1'b1;
    key_onehot = k;
    tick();
    key_valid = 1'b0;
    key_onehot = '0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_entry", 32'(entry), 32'h0);
    check("rst_cnt", 32'(cnt), 32'h0);
    check("rst_flags", {28'h0, acc, err, ovf, vld}, 32'h0);
    tick();
    rst_n = 1'b1;
    key(10'h002); check("k1_acc", 32'(acc), 32'h1);
    key(10'h004); check("k2_acc", 32'(acc), 32'h1);
    key(10'h008); check("k3_acc", 32'(acc), 32'h1);
    check("k123_entry", 32'(entry), 32'h0123);
    check("k123_cnt", 32'(cnt), 32'h3);
    tick();
    check("acc_drop", 32'(acc), 32'h0);
    pulse_clear();
    key(10'h200); key(10'h100); key(10'h080); key(10'h040);
    check("full_entry", 32'(entry), 32'h9876);
    check("full_flag", 32'(full), 32'h1);
    check("full_ovf0", 32'(ovf), 32'h0);
    key(10'h020);
    check("ovf_entry", 32'(entry), 32'h9876);
    check("ovf_flag", 32'(ovf), 32'h1);
    check("ovf_noacc", 32'(acc), 32'h0);
    backspace = 1'b1; tick(); backspace = 1'b0;
    check("bs_entry", 32'(entry), 32'h0987);
    check("bs_cnt", 32'(cnt), 32'h3);
    check("bs_ovf", 32'(ovf), 32'h0);
    check("bs_full", 32'(full), 32'h0);
    pulse_clear();
    backspace = 1'b1; tick(); backspace = 1'b0;
    check("bs_empty_cnt", 32'(cnt), 32'h0);
    key(10'h003);
    check("err_multi", 32'(err), 32'h1);
    check("err_multi_p", 32'(err0), 32'h1);
    check("err_entry", 32'(entry), 32'h0);
    key(10'h000);
    check("err_zero", 32'(err), 32'h1);
    check("err_cnt", 32'(cnt), 32'h0);
    tick();
    check("err_sticky", 32'(err), 32'h1);
    check("err_pulse_drop", 32'(err0), 32'h0);
    pulse_clear();
    check("clr_err", 32'(err), 32'h0);
    key(10'h010); key(10'h004);
    check("e42_entry", 32'(entry), 32'h0042);
    enter = 1'b1; tick(); enter = 1'b0;
    check("commit_vld", 32'(vld), 32'h1);
    check("commit_val", 32'(value), 32'h0042);
    check("commit_clr", 32'(entry), 32'h0);
    key(10'h080);
    check("hold_key", 32'(entry), 32'h0007);
    tick(); tick();
    enter = 1'b1; tick(); enter = 1'b0;
    check("hold_val", 32'(value), 32'h0042);
    check("hold_vld", 32'(vld), 32'h1);
    check("hold_entry", 32'(entry), 32'h0007);
    check("hold_cnt", 32'(cnt), 32'h1);
    value_ready = 1'b1; tick(); value_ready = 1'b0;
    check("ready_vld", 32'(vld), 32'h0);
    enter = 1'b1; tick();
    check("c7_val", 32'(value), 32'h0007);
    check("c7_vld", 32'(vld), 32'h1);
    value_ready = 1'b1; tick(); value_ready = 1'b0;
    check("en_rdy_vld", 32'(vld), 32'h0);
    check("en_rdy_val", 32'(value), 32'h0007);
    tick(); enter = 1'b0;
    check("zero_val", 32'(value), 32'h0);
    check("zero_vld", 32'(vld), 32'h1);
    key(10'h020); key(10'h000);
    key_valid = 1'b1; key_onehot = 10'h008; backspace = 1'b1; clear = 1'b1;
    tick();
    key_valid = 1'b0; key_onehot = '0; backspace = 1'b0; clear = 1'b0;
    check("prio_entry", 32'(entry), 32'h0);
    check("prio_cnt", 32'(cnt), 32'h0);
    check("prio_flags", {29'h0, acc, err, ovf}, 32'h0);
    check("prio_vld", 32'(vld), 32'h1);
    key(10'h100);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vld", 32'(vld), 32'h0);
    check("arst_val", 32'(value), 32'h0);
    check("arst_entry", 32'(entry), 32'h0);
    check("arst_cnt", 32'(cnt), 32'h0);
    tick();
    rst_n = 1'b1;
    key(10'h002);
    check("post_rst_entry", 32'(entry), 32'h0001);
    check("post_rst_acc", 32'(acc), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/onehot_bcd_entry.md
ONEHOT_BCD_ENTRY -- requirements
Module: onehot_bcd_entry

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of BCD digits held in the entry register (legal range 1..8).
REQ-002 The block SHALL have parameter STICKY_ERR, default 1, meaning err is sticky when 1 and a one-cycle pulse when 0.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port key_valid  input  1  key_onehot is presented this cycle.
REQ-007 The block SHALL have port key_onehot  input  10  one-hot decimal key; bit k set means digit k.
REQ-008 The block SHALL have port backspace  input  1  remove the most recently entered digit.
REQ-009 The block SHALL have port clear  input  1  discard the entry and clear flags.
REQ-010 The block SHALL have port enter  input  1  commit the entry to the output holding register.
REQ-011 The block SHALL have port entry_bcd  output  4*DIGITS  live entry; digit 0 (newest) in bits [3:0].
REQ-012 The block SHALL have port digit_count  output  $clog2(DIGITS+1)  number of digits currently entered.
REQ-013 The block SHALL have port full  output  1  digit_count == DIGITS.
REQ-014 The block SHALL have port key_accept  output  1  one-cycle pulse: a key was stored on the previous edge.
REQ-015 The block SHALL have port err  output  1  a non-one-hot key (zero or multiple bits set) was presented.
REQ-016 The block SHALL have port ovf  output  1  sticky; a valid key arrived while full.
REQ-017 The block SHALL have port value_bcd  output  4*DIGITS  committed value, stable while value_valid is high.
REQ-018 The block SHALL have port value_valid  output  1  committed value available.
REQ-019 The block SHALL have port value_ready  input  1  consumer accepts value_bcd.

Function
REQ-020 All registered outputs SHALL update only on the rising edge of clk; full SHALL be decoded combinationally from digit_count.
REQ-021 Per-cycle priority SHALL be: clear > enter > backspace > key_valid; a lower-priority request in the same cycle SHALL be dropped with no flag change.
REQ-022 A valid one-hot key with digit_count < DIGITS SHALL shift entry_bcd left by 4, insert the decoded digit in bits [3:0], increment digit_count, and pulse key_accept on the next cycle (latency 1).
REQ-023 A digit-0 key SHALL be stored and counted like any other digit (leading zeros are retained).
REQ-024 A key with key_valid high and key_onehot not exactly one-hot SHALL leave entry_bcd and digit_count unchanged and set err (held if STICKY_ERR=1, one cycle if 0).
REQ-025 A valid key while full SHALL leave entry_bcd and digit_count unchanged and set ovf; key_accept SHALL stay low.
REQ-026 Backspace with digit_count > 0 SHALL shift entry_bcd right by 4 with zero fill in the top digit, decrement digit_count, and clear ovf; with digit_count == 0 it SHALL be a no-op.
REQ-027 Clear SHALL zero entry_bcd and digit_count and clear err and ovf; it SHALL NOT affect value_bcd or value_valid.
REQ-028 The output handshake SHALL be a two-state machine, IDLE (value_valid=0) and HOLD (value_valid=1).
REQ-029 In IDLE, enter SHALL copy entry_bcd to value_bcd, go to HOLD, and clear the entry as for clear, all on the same edge.
REQ-030 In HOLD, value_ready high SHALL return the machine to IDLE on the next edge; value_bcd SHALL remain stable until then.
REQ-031 In HOLD, enter SHALL be ignored (entry retained, no flag change); key entry, backspace, and clear SHALL continue to operate.
REQ-032 Enter and value_ready in the same HOLD cycle SHALL complete the transfer and return to IDLE; the new enter SHALL be dropped.
REQ-033 Enter with digit_count == 0 SHALL commit an all-zero value.

Reset
REQ-034 While rst_n is low, entry_bcd, digit_count, value_bcd SHALL be 0; key_accept, err, ovf, value_valid SHALL be 0; state SHALL be IDLE; this SHALL take effect immediately, independent of clk.
REQ-035 Reset asserted mid-entry or in HOLD SHALL discard all data; the first edge after release SHALL process inputs normally.

Verification
REQ-036 DIGITS=4: keys 1,2,3 (10'h002, 10'h004, 10'h008) -> entry_bcd=16'h0123, digit_count=3, three key_accept pulses.
REQ-037 Keys 9,8,7,6,5 -> entry_bcd=16'h9876, full=1, ovf=1 after 5th; then backspace -> 16'h0987, count=3, ovf=0.
REQ-038 key_onehot=10'h003 then 10'h000 with key_valid -> entry unchanged, err=1 sticky; STICKY_ERR=0 -> err high one cycle only.
REQ-039 Entry 16'h0042, enter, value_ready low 3 cycles, second enter -> value_bcd=16'h0042 held, value_valid=1, entry unaffected by second enter; value_ready=1 -> value_valid=0 next cycle.
REQ-040 Key, backspace, and clear in the same cycle -> clear wins: entry 0, flags 0; rst_n low mid-HOLD -> all outputs 0 immediately.
